// File: rtl/time_surface_scan_reader.sv
// time_surface_scan_reader: read-side scan initiator for the time-surface memory.
// Sweeps all GRID_SIZE*GRID_SIZE cells in ascending address order. Reads go to a
// fixed-latency memory, and the returned values leave on a valid/ready stream
// tagged with (x, y). Reads are only issued when a FIFO slot is guaranteed, so no
// in-flight read is ever dropped.
// Optional build macro: SCAN_STATS_EN builds the stat_sum / stat_nonzero
// accumulators. Without it those ports are tied to zero.
module time_surface_scan_reader #(
  parameter int GRID_SIZE    = 16,
  parameter int ADDR_BITS    = 8,
  parameter int VALUE_BITS   = 8,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            scan_start,
  output logic                            scan_busy,
  output logic                            scan_done,
  output logic                            mem_read_enable,
  output logic [ADDR_BITS-1:0]            mem_read_addr,
  input  logic [VALUE_BITS-1:0]           mem_read_value,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [VALUE_BITS-1:0]           out_value,
  output logic [$clog2(GRID_SIZE)-1:0]    out_x,
  output logic [$clog2(GRID_SIZE)-1:0]    out_y,
  output logic                            out_last,
  output logic [VALUE_BITS+ADDR_BITS-1:0] stat_sum,
  output logic [ADDR_BITS:0]              stat_nonzero
);

  localparam int XB = $clog2(GRID_SIZE);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(GRID_SIZE * GRID_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q;
  logic [ADDR_BITS-1:0]   addr_hold_q;
  logic                   last_seen_q;
  logic [READ_LATENCY-1:0] tag_vld_q;
  logic [ADDR_BITS-1:0]   tag_addr_q [READ_LATENCY];
  logic [VALUE_BITS-1:0]  fifo_val_q [FIFO_DEPTH];
  logic [ADDR_BITS-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          occ_q, occ_d;
  logic [CW-1:0]          inflight;
  logic [ADDR_BITS-1:0]   head_addr;
  logic                   start_acc, issue, push, pop, last_pop;

  // Count reads still travelling through the memory latency pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CW'(tag_vld_q[i]);
    end
  end

  // Credit check counts the FIFO slots already promised; a pop this cycle gives no credit.
  assign start_acc = (state_q == ST_IDLE) && scan_start;
  assign issue     = (state_q == ST_SCAN) && ((inflight + occ_q) < CW'(FIFO_DEPTH));
  assign push      = tag_vld_q[READ_LATENCY-1];
  assign out_valid = (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign occ_d     = occ_q + CW'(push) - CW'(pop);

  assign head_addr = out_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign out_value = out_valid ? fifo_val_q[rd_ptr_q] : '0;
  assign out_x     = head_addr[XB-1:0];
  assign out_y     = head_addr[ADDR_BITS-1:XB];
  assign out_last  = out_valid && (head_addr == LAST_ADDR);
  assign last_pop  = pop && out_last;

  assign mem_read_addr   = issue ? cnt_q : addr_hold_q;
  assign mem_read_enable = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign scan_busy       = (state_q != ST_IDLE);
  assign scan_done       = (state_q == ST_DONE);

  // Next-state logic of the sweep controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (scan_start) state_d = ST_SCAN;
      ST_SCAN:  if (issue && (cnt_q == LAST_ADDR)) state_d = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && (occ_d == '0) && (last_seen_q || last_pop))
                  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register, address counter, held address and last-handshake flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_hold_q <= '0;
      last_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        cnt_q       <= '0;
        last_seen_q <= 1'b0;
      end else begin
        if (issue) begin
          cnt_q       <= cnt_q + 1'b1;
          addr_hold_q <= cnt_q;
        end
        if (last_pop) last_seen_q <= 1'b1;
      end
    end
  end

  // Tag pipeline mirrors the memory latency so each returned value gets its address.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
    // One tag stage: stage 0 takes the issued read, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_vld_q[gi]  <= 1'b0;
        tag_addr_q[gi] <= '0;
      end else if (gi == 0) begin
        tag_vld_q[gi]  <= issue;
        tag_addr_q[gi] <= cnt_q;
      end else begin
        tag_vld_q[gi]  <= tag_vld_q[(gi > 0) ? gi - 1 : 0];
        tag_addr_q[gi] <= tag_addr_q[(gi > 0) ? gi - 1 : 0];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_val_q[wr_ptr_q]  <= mem_read_value;
      fifo_addr_q[wr_ptr_q] <= tag_addr_q[READ_LATENCY-1];
    end
  end

`ifdef SCAN_STATS_EN
  localparam int SW = VALUE_BITS + ADDR_BITS;
  logic [SW-1:0]        sum_q;
  logic [ADDR_BITS:0]   nz_q;

  // Accumulate emitted values; cleared by an accepted start, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      nz_q  <= '0;
    end else if (start_acc) begin
      sum_q <= '0;
      nz_q  <= '0;
    end else if (pop) begin
      sum_q <= sum_q + SW'(out_value);
      nz_q  <= nz_q + (ADDR_BITS + 1)'(out_value != '0);
    end
  end

  assign stat_sum     = sum_q;
  assign stat_nonzero = nz_q;
`else
  assign stat_sum     = '0;
  assign stat_nonzero = '0;
`endif

endmodule

// File: tb/tb_time_surface_scan_reader.sv
// Scoreboard bench for time_surface_scan_reader: the expected beat sequence of a
// sweep is derived from the memory image and queued; a negedge monitor pops and
// compares every handshake.
module tb_time_surface_scan_reader;
  localparam int N = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_start = 1'b0;
  logic       out_ready = 1'b1;
  logic       scan_busy, scan_done, mem_read_enable, out_valid, out_last;
  logic [7:0] mem_read_addr, mem_read_value, out_value;
  logic [3:0] out_x, out_y;
  logic [15:0] stat_sum;
  logic [8:0]  stat_nonzero;

  time_surface_scan_reader dut (
    .clk(clk), .rst_n(rst_n), .scan_start(scan_start),
    .scan_busy(scan_busy), .scan_done(scan_done),
    .mem_read_enable(mem_read_enable), .mem_read_addr(mem_read_addr),
    .mem_read_value(mem_read_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_x(out_x), .out_y(out_y), .out_last(out_last),
    .stat_sum(stat_sum), .stat_nonzero(stat_nonzero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle-latency memory model, free running.
  logic [7:0] mem [N];
  logic [7:0] rd1 = 8'd0, rd2 = 8'd0;
  always @(posedge clk) begin
    rd1 <= mem[mem_read_addr];
    rd2 <= rd1;
  end
  assign mem_read_value = rd2;

  typedef struct {
    logic [7:0] v;
    logic [3:0] x;
    logic [3:0] y;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  int total = 0, bad = 0;
  int beats = 0, done_cnt = 0, start_cyc = 0;
  int exp_sum = 0, exp_nz = 0;
  int ready_mode = 0;
  bit timing_chk = 0;
  bit prev_stall = 0;
  logic [17:0] prev_pk = '0;

  task automatic check(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = ready 70% of cycles, 2 = held low.
  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 99) < 70);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: stability under stall, credit bound, beat compare, done/stats.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", int'({out_valid, out_value, out_x, out_y, out_last}), int'(prev_pk));
      prev_pk    = {out_valid, out_value, out_x, out_y, out_last};
      prev_stall = out_valid && !out_ready;
      if (scan_busy)
        check("credit_bound", int'(int'(mem_read_addr) + 1 - beats <= 4), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_value", int'(out_value), int'(e.v));
          check("beat_x", int'(out_x), int'(e.x));
          check("beat_y", int'(out_y), int'(e.y));
          check("beat_last", int'(out_last), int'(e.last));
          if (timing_chk) check("beat_cycle", cyc - start_cyc, 4 + beats);
        end
        beats++;
      end
      if (scan_done) begin
        done_cnt++;
        if (timing_chk) check("done_cycle", cyc - start_cyc, 260);
        check("done_stat_sum", int'(stat_sum), exp_sum);
        check("done_stat_nonzero", int'(stat_nonzero), exp_nz);
      end
    end
  end

  // Reference model: one beat per cell in ascending address order.
  task automatic load_expected();
    beat_t b;
    exp_q.delete();
    exp_sum = 0;
    exp_nz  = 0;
    for (int a = 0; a < N; a++) begin
      b.v    = mem[a];
      b.x    = 4'(a % 16);
      b.y    = 4'(a / 16);
      b.last = (a == N - 1);
      exp_q.push_back(b);
      exp_sum += int'(mem[a]);
      if (mem[a] != 0) exp_nz++;
    end
`ifndef SCAN_STATS_EN
    exp_sum = 0;
    exp_nz  = 0;
`endif
  endtask

  task automatic start_sweep();
    @(posedge clk);
    #1;
    beats      = 0;
    done_cnt   = 0;
    scan_start = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    scan_start = 1'b0;
  endtask

  task automatic finish_sweep(string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_beats"}, beats, N);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_busy_after"}, int'(scan_busy), 0);
    check({tag, "_sum_hold"}, int'(stat_sum), exp_sum);
    check({tag, "_nonzero_hold"}, int'(stat_nonzero), exp_nz);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_busy"}, int'(scan_busy), 0);
    check({tag, "_done"}, int'(scan_done), 0);
    check({tag, "_rd_en"}, int'(mem_read_enable), 0);
    check({tag, "_rd_addr"}, int'(mem_read_addr), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_value"}, int'(out_value), 0);
    check({tag, "_x"}, int'(out_x), 0);
    check({tag, "_y"}, int'(out_y), 0);
    check({tag, "_last"}, int'(out_last), 0);
    check({tag, "_sum"}, int'(stat_sum), 0);
    check({tag, "_nonzero"}, int'(stat_nonzero), 0);
  endtask

  initial begin
    for (int a = 0; a < N; a++) mem[a] = 8'(a);
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("por");
    rst_n = 1'b1;

    // Ramp image, always ready: exact cycle timing.
    load_expected();
    ready_mode = 0;
    timing_chk = 1;
    start_sweep();
    finish_sweep("ramp_ready");
    timing_chk = 0;
    $display("sweep ramp_ready: beats=%0d sum=%0d nonzero=%0d", beats, stat_sum, stat_nonzero);

    // Ramp image, random backpressure.
    load_expected();
    ready_mode = 1;
    start_sweep();
    finish_sweep("ramp_random");
    ready_mode = 0;
    $display("sweep ramp_random: beats=%0d", beats);

    // Ready held low for 50 cycles: exactly FIFO_DEPTH reads go out.
    load_expected();
    ready_mode = 2;
    start_sweep();
    repeat (48) @(posedge clk);
    #1;
    check("stall_rd_addr", int'(mem_read_addr), 3);
    check("stall_beats", beats, 0);
    check("stall_valid", int'(out_valid), 1);
    check("stall_head_value", int'(out_value), 0);
    ready_mode = 0;
    finish_sweep("stall_release");
    $display("sweep stall_release: beats=%0d", beats);

    // Second start mid-sweep is ignored.
    load_expected();
    timing_chk = 1;
    start_sweep();
    while (cyc < start_cyc + 100) @(posedge clk);
    #1;
    scan_start = 1'b1;
    @(posedge clk);
    #1;
    scan_start = 1'b0;
    finish_sweep("restart_ignored");
    timing_chk = 0;
    $display("sweep restart_ignored: beats=%0d dones=%0d", beats, done_cnt);

    // Reset mid-sweep, then a clean sweep.
    load_expected();
    ready_mode = 1;
    start_sweep();
    while (cyc < start_cyc + 120) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_expected();
    start_sweep();
    finish_sweep("after_reset");
    ready_mode = 0;
    $display("sweep after_reset: beats=%0d", beats);

    // All-zero image.
    for (int a = 0; a < N; a++) mem[a] = 8'd0;
    load_expected();
    ready_mode = 1;
    start_sweep();
    finish_sweep("all_zero");
    $display("sweep all_zero: beats=%0d nonzero=%0d", beats, stat_nonzero);

    // Random image with some zero cells.
    for (int a = 0; a < N; a++)
      mem[a] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    load_expected();
    start_sweep();
    finish_sweep("random_image");
    ready_mode = 0;
    $display("sweep random_image: beats=%0d sum=%0d", beats, stat_sum);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
